// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Purpose  : 640x480@60 Hz raster constants, derived sync windows, counter
//             widths and the saturating cursor-step helper.
//  Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

  // Counter and cursor widths
  localparam int CNT_W = 10;
  localparam int SEL_W = 4;

  // Horizontal timing (pixels)
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  // Vertical timing (lines)
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sync windows: [start, end)
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // System clocks per pixel and cursor grid
  localparam int CLK_DIV = 2;
  localparam int COLS    = 8;
  localparam int ROWS    = 8;

  // One cursor step on one axis: opposing requests cancel, ends saturate.
  function automatic logic [SEL_W-1:0] sat_step(
    input logic [SEL_W-1:0] cur,
    input logic             dec,
    input logic             inc,
    input logic [SEL_W-1:0] max_val
  );
    logic [SEL_W-1:0] res;
    res = cur;
    if (dec && !inc && (cur != '0)) begin
      res = cur - 1'b1;
    end else if (inc && !dec && (cur < max_val)) begin
      res = cur + 1'b1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_sel_cursor.sv
`default_nettype none
// ============================================================================
//  Module   : sel_cursor
//  Purpose  : Selection cursor. Button pulses are latched as pending requests
//             and committed only on frame_start, so a frame never tears and
//             each axis moves at most one step per frame.
//  Revision : 1.0 - initial release
// ============================================================================
module sel_cursor
  import vga_pkg::*;
#(
  parameter int COLS = 8,
  parameter int ROWS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_up,
  input  logic             btn_down,
  output logic [SEL_W-1:0] x_select,
  output logic [SEL_W-1:0] y_select
);

  localparam logic [SEL_W-1:0] X_MAX = SEL_W'(COLS - 1);
  localparam logic [SEL_W-1:0] Y_MAX = SEL_W'(ROWS - 1);

  logic pend_l;
  logic pend_r;
  logic pend_u;
  logic pend_d;

  // Pending flags: sticky within a frame; in the commit cycle they reload
  // from the buttons so a pulse landing on frame_start carries into the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_l <= 1'b0;
      pend_r <= 1'b0;
      pend_u <= 1'b0;
      pend_d <= 1'b0;
    end else if (frame_start) begin
      pend_l <= btn_left;
      pend_r <= btn_right;
      pend_u <= btn_up;
      pend_d <= btn_down;
    end else begin
      pend_l <= pend_l | btn_left;
      pend_r <= pend_r | btn_right;
      pend_u <= pend_u | btn_up;
      pend_d <= pend_d | btn_down;
    end
  end

  // Cursor registers: commit the pending step at the frame boundary only.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_select <= '0;
      y_select <= '0;
    end else if (frame_start) begin
      x_select <= sat_step(x_select, pend_l, pend_r, X_MAX);
      y_select <= sat_step(y_select, pend_u, pend_d, Y_MAX);
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : 640x480@60 Hz raster generator: pixel enable / pixel clock,
//             x/y counters, registered hsync/vsync/blank_n aligned with the
//             counters, frame_start strobe and the frame-synchronous cursor.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int CLK_DIV  = vga_pkg::CLK_DIV,  // must be >= 2
  parameter int COLS     = vga_pkg::COLS,
  parameter int ROWS     = vga_pkg::ROWS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_up,
  input  logic             btn_down,
  output logic             vga_clk,
  output logic             pix_en,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             hsync,
  output logic             vsync,
  output logic             blank_n,
  output logic             sync_n,
  output logic             frame_start,
  output logic [SEL_W-1:0] x_select,
  output logic [SEL_W-1:0] y_select
);

  // Raster geometry for this instance
  localparam int LOC_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int LOC_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(LOC_H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(LOC_V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // Divider geometry
  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] x_nxt;
  logic [CNT_W-1:0] y_nxt;
  logic             wrap;

  // Pixel divider: free-running 0..CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // pix_en marks the last clk of each pixel; vga_clk rises mid-pixel so the
  // DAC latches data that has been stable for half a pixel.
  assign pix_en  = (div == DIV_LAST);
  assign vga_clk = (div >= DIV_HALF);
  assign sync_n  = 1'b0;

  // Next raster position; wrap flags the (last,last) -> (0,0) transition.
  always_comb begin
    x_nxt = x;
    y_nxt = y;
    wrap  = 1'b0;
    if (pix_en) begin
      if (x == H_LAST) begin
        x_nxt = '0;
        if (y == V_LAST) begin
          y_nxt = '0;
          wrap  = 1'b1;
        end else begin
          y_nxt = y + 1'b1;
        end
      end else begin
        x_nxt = x + 1'b1;
      end
    end
  end

  // Counters and sync/blank decode. Decoding from x_nxt/y_nxt and registering
  // keeps the strobes glitch-free and in the same cycle as the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank_n     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      x           <= x_nxt;
      y           <= y_nxt;
      hsync       <= !((x_nxt >= HS_START) && (x_nxt < HS_END));
      vsync       <= !((y_nxt >= VS_START) && (y_nxt < VS_END));
      blank_n     <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
      frame_start <= wrap;
    end
  end

  sel_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_sel_cursor (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .x_select    (x_select),
    .y_select    (y_select)
  );

endmodule
`default_nettype wire
